// File: rtl/shwr_integral_readout_pkg.sv
// Shared widths, defaults and types for the shower integral readout.
// Entry layout MSB..LSB: evt_id, trunc, sat, peak, baseline, integral.
package shwr_integral_readout_pkg;

  localparam int ADC_WIDTH                = 12;
  localparam int SHWR_AREA_WIDTH          = 19;
  localparam int SHWR_BASELINE_EXTRA_BITS = 2;
  localparam int SHWR_AREA_BINS           = 5;

  localparam int SHWR_RDOUT_FIFO_DEPTH = 4;
  localparam int SHWR_RDOUT_SETTLE     = SHWR_AREA_BINS + 3;

  localparam int EVT_W   = 12;
  localparam int BASE_W  = ADC_WIDTH + SHWR_BASELINE_EXTRA_BITS;
  localparam int ENTRY_W = EVT_W + 2 + ADC_WIDTH + BASE_W
                         + SHWR_AREA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } cap_state_t;

  typedef struct packed {
    logic [EVT_W-1:0]           evt_id;
    logic                       trunc;
    logic                       sat;
    logic [ADC_WIDTH-1:0]       peak;
    logic [BASE_W-1:0]          baseline;
    logic [SHWR_AREA_WIDTH-1:0] integral;
  } rdout_entry_t;

endpackage

// File: rtl/shwr_rdout_fifo.sv
// Readout FIFO: storage, wrap-bit pointers, flags, registered pop port.
// Ports: clk, rst_n, wr_en/wr_data, rd_en -> rd_data/rd_valid, empty, full.
module shwr_rdout_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW])
              && (wp[AW-1:0] == rp[AW-1:0]);

  // A pop frees a slot on the same edge, so a full FIFO still
  // accepts a write when it is popped at the same time.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) begin
        rp      <= rp + 1'b1;
        rd_data <= mem[rp[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/shwr_integral_readout.sv
// Captures one integral result per trigger window into a readout FIFO.
// Ports: CLK120, RESET_N, TRIGGERED, producer fields, RD_EN -> FIFO outputs.
module shwr_integral_readout
  import shwr_integral_readout_pkg::*;
#(
  parameter int FIFO_DEPTH = SHWR_RDOUT_FIFO_DEPTH,
  parameter int SETTLE     = SHWR_RDOUT_SETTLE
) (
  input  logic                       CLK120,
  input  logic                       RESET_N,
  input  logic                       TRIGGERED,
  input  logic [SHWR_AREA_WIDTH-1:0] INTEGRAL,
  input  logic [BASE_W-1:0]          BASELINE,
  input  logic [ADC_WIDTH-1:0]       PEAK,
  input  logic                       SATURATED,
  input  logic                       RD_EN,
  output logic [ENTRY_W-1:0]         RD_DATA,
  output logic                       RD_VALID,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic [7:0]                 OVERFLOW_CNT
);

  localparam int CW = $clog2(SETTLE + 1);

  cap_state_t   state;
  logic [CW-1:0] cnt;
  logic [EVT_W-1:0] evt_id;
  logic         cap;
  logic         trunc;
  logic         drop;
  rdout_entry_t ent;

  // A falling window while counting captures the still-frozen
  // producer values early and flags them as truncated.
  always_comb begin
    cap   = 1'b0;
    trunc = 1'b0;
    if (state == S_COUNT) begin
      if (!TRIGGERED) begin
        cap   = 1'b1;
        trunc = 1'b1;
      end else if (cnt == CW'(SETTLE)) begin
        cap = 1'b1;
      end
    end
  end

  assign drop = cap && FULL && !RD_EN;

  always_comb begin
    ent.evt_id   = evt_id;
    ent.trunc    = trunc;
    ent.sat      = SATURATED;
    ent.peak     = PEAK;
    ent.baseline = BASELINE;
    ent.integral = INTEGRAL;
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_IDLE;
      cnt          <= '0;
      evt_id       <= '0;
      OVERFLOW_CNT <= '0;
    end else begin
      if (cap) evt_id <= evt_id + 1'b1;
      if (drop && OVERFLOW_CNT != 8'hff)
        OVERFLOW_CNT <= OVERFLOW_CNT + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (TRIGGERED) begin
            state <= S_COUNT;
            cnt   <= CW'(1);
          end
        end
        S_COUNT: begin
          if (!TRIGGERED) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(SETTLE)) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!TRIGGERED) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  shwr_rdout_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK120),
    .rst_n    (RESET_N),
    .wr_en    (cap),
    .wr_data  (ent),
    .rd_en    (RD_EN),
    .rd_data  (RD_DATA),
    .rd_valid (RD_VALID),
    .empty    (EMPTY),
    .full     (FULL)
  );

endmodule
